// File: rtl/nes_mem_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : nes_mem_arbiter                                            |
// | Description : Serialises mapper-translated CPU (PRG) and PPU (CHR)       |
// |               accesses onto one shared external memory port.            |
// |               Each side has one pending slot. The PPU has priority,     |
// |               but the CPU is guaranteed every second grant while it is  |
// |               waiting. Accesses the mapper forbids (allow=0) are        |
// |               acknowledged without touching memory.                     |
// | Ports       : clk, reset (sync, active-high)                             |
// |               cpu_* / ppu_* : req strobe, addr, we, wdata, allow in;     |
// |                               rdata, one-cycle done pulse out           |
// |               mem_*         : addr/rd/wr/wdata out, rdata/ready in      |
// |               overflow      : sticky, a request hit a busy slot         |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module nes_mem_arbiter #(
   parameter int ADDR_W = 22,
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cpu_req,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic              cpu_we,
   input  logic [DATA_W-1:0] cpu_wdata,
   input  logic              cpu_allow,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              cpu_done,
   input  logic              ppu_req,
   input  logic [ADDR_W-1:0] ppu_addr,
   input  logic              ppu_we,
   input  logic [DATA_W-1:0] ppu_wdata,
   input  logic              ppu_allow,
   output logic [DATA_W-1:0] ppu_rdata,
   output logic              ppu_done,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_rd,
   output logic              mem_wr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ready,
   output logic              overflow
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DENY   = 2'd2
   } state_t;

   localparam logic SIDE_CPU = 1'b0;
   localparam logic SIDE_PPU = 1'b1;

   state_t            state, state_nxt;
   logic              side, side_nxt;
   logic              last_grant, last_grant_nxt;
   logic [ADDR_W-1:0] mem_addr_nxt;
   logic [DATA_W-1:0] mem_wdata_nxt;
   logic              mem_rd_nxt, mem_wr_nxt;
   logic [DATA_W-1:0] cpu_rdata_nxt, ppu_rdata_nxt;
   logic              cpu_done_nxt, ppu_done_nxt;

   // Pending slots
   logic              cpu_busy, ppu_busy;
   logic [ADDR_W-1:0] cpu_s_addr, ppu_s_addr;
   logic              cpu_s_we, ppu_s_we;
   logic [DATA_W-1:0] cpu_s_wdata, ppu_s_wdata;
   logic              cpu_s_allow, ppu_s_allow;

   logic              cpu_finish, ppu_finish;
   logic              win;
   logic [ADDR_W-1:0] win_addr;
   logic              win_we;
   logic [DATA_W-1:0] win_wdata;
   logic              win_allow;

   // A slot completes in the cycle its done pulse is being generated; a new
   // request arriving in that same cycle may reuse the slot.
   assign cpu_finish = (side == SIDE_CPU) &&
                       ((state == DENY) || ((state == ACCESS) && mem_ready));
   assign ppu_finish = (side == SIDE_PPU) &&
                       ((state == DENY) || ((state == ACCESS) && mem_ready));

   // PPU wins unless it was granted last and the CPU is waiting.
   assign win       = ppu_busy && !((last_grant == SIDE_PPU) && cpu_busy);
   assign win_addr  = win ? ppu_s_addr  : cpu_s_addr;
   assign win_we    = win ? ppu_s_we    : cpu_s_we;
   assign win_wdata = win ? ppu_s_wdata : cpu_s_wdata;
   assign win_allow = win ? ppu_s_allow : cpu_s_allow;

   always_ff @(posedge clk) begin
      if (reset) begin
         cpu_busy    <= 1'b0;
         ppu_busy    <= 1'b0;
         cpu_s_addr  <= '0;
         ppu_s_addr  <= '0;
         cpu_s_we    <= 1'b0;
         ppu_s_we    <= 1'b0;
         cpu_s_wdata <= '0;
         ppu_s_wdata <= '0;
         cpu_s_allow <= 1'b0;
         ppu_s_allow <= 1'b0;
         overflow    <= 1'b0;
      end else begin
         if (cpu_req && (!cpu_busy || cpu_finish)) begin
            cpu_busy    <= 1'b1;
            cpu_s_addr  <= cpu_addr;
            cpu_s_we    <= cpu_we;
            cpu_s_wdata <= cpu_wdata;
            cpu_s_allow <= cpu_allow;
         end else if (cpu_finish) begin
            cpu_busy    <= 1'b0;
         end

         if (ppu_req && (!ppu_busy || ppu_finish)) begin
            ppu_busy    <= 1'b1;
            ppu_s_addr  <= ppu_addr;
            ppu_s_we    <= ppu_we;
            ppu_s_wdata <= ppu_wdata;
            ppu_s_allow <= ppu_allow;
         end else if (ppu_finish) begin
            ppu_busy    <= 1'b0;
         end

         if ((cpu_req && cpu_busy && !cpu_finish) ||
             (ppu_req && ppu_busy && !ppu_finish)) begin
            overflow <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         side       <= SIDE_CPU;
         last_grant <= SIDE_CPU;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         mem_rd     <= 1'b0;
         mem_wr     <= 1'b0;
         cpu_rdata  <= '0;
         ppu_rdata  <= '0;
         cpu_done   <= 1'b0;
         ppu_done   <= 1'b0;
      end else begin
         state      <= state_nxt;
         side       <= side_nxt;
         last_grant <= last_grant_nxt;
         mem_addr   <= mem_addr_nxt;
         mem_wdata  <= mem_wdata_nxt;
         mem_rd     <= mem_rd_nxt;
         mem_wr     <= mem_wr_nxt;
         cpu_rdata  <= cpu_rdata_nxt;
         ppu_rdata  <= ppu_rdata_nxt;
         cpu_done   <= cpu_done_nxt;
         ppu_done   <= ppu_done_nxt;
      end
   end

   always_comb begin
      state_nxt      = state;
      side_nxt       = side;
      last_grant_nxt = last_grant;
      mem_addr_nxt   = mem_addr;
      mem_wdata_nxt  = mem_wdata;
      mem_rd_nxt     = mem_rd;
      mem_wr_nxt     = mem_wr;
      cpu_rdata_nxt  = cpu_rdata;
      ppu_rdata_nxt  = ppu_rdata;
      cpu_done_nxt   = 1'b0;
      ppu_done_nxt   = 1'b0;

      case (state)
         IDLE: begin
            if (cpu_busy || ppu_busy) begin
               side_nxt = win;
               if (win_allow) begin
                  mem_addr_nxt   = win_addr;
                  mem_wdata_nxt  = win_wdata;
                  mem_rd_nxt     = !win_we;
                  mem_wr_nxt     = win_we;
                  last_grant_nxt = win;
                  state_nxt      = ACCESS;
               end else begin
                  state_nxt = DENY;
               end
            end
         end
         ACCESS: begin
            if (mem_ready) begin
               mem_rd_nxt = 1'b0;
               mem_wr_nxt = 1'b0;
               if (mem_rd) begin
                  if (side == SIDE_PPU) ppu_rdata_nxt = mem_rdata;
                  else                  cpu_rdata_nxt = mem_rdata;
               end
               if (side == SIDE_PPU) ppu_done_nxt = 1'b1;
               else                  cpu_done_nxt = 1'b1;
               state_nxt = IDLE;
            end
         end
         DENY: begin
            if (side == SIDE_PPU) ppu_done_nxt = 1'b1;
            else                  cpu_done_nxt = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

endmodule
`default_nettype wire

// File: doc/nes_mem_arbiter.md
Name: nes_mem_arbiter

Overview:
- Sits directly downstream of the cartridge mapper.
- Takes the mapper-translated PRG (CPU) and CHR (PPU) addresses and allow flags, and serialises them onto one shared external memory port (SDRAM/SRAM controller front end) using a request/ready handshake.
- Returns read data and a one-cycle done pulse to each requester.
- PPU accesses have priority because of video timing. An anti-starvation rule guarantees the CPU is served.

Parameters:
- ADDR_W, 22, width of mapped memory address (matches mapper prg/chr output width)
- DATA_W, 8, data width of both requesters and the memory port

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- cpu_req  in  1  one-cycle strobe: CPU access this cycle
- cpu_addr  in  ADDR_W  mapped PRG address
- cpu_we  in  1  1=write, 0=read (sampled with cpu_req)
- cpu_wdata  in  DATA_W  write data
- cpu_allow  in  1  mapper permits this access
- cpu_rdata  out  DATA_W  read data, valid when cpu_done
- cpu_done  out  1  one-cycle completion pulse
- ppu_req, ppu_addr, ppu_we, ppu_wdata, ppu_allow  in  1/ADDR_W/1/DATA_W/1  same as CPU side, for CHR
- ppu_rdata  out  DATA_W  read data, valid when ppu_done
- ppu_done  out  1  one-cycle completion pulse
- mem_addr  out  ADDR_W  memory address
- mem_rd  out  1  read command, held until accepted
- mem_wr  out  1  write command, held until accepted
- mem_wdata  out  DATA_W  write data
- mem_rdata  in  DATA_W  read data, valid in the mem_ready cycle of a read
- mem_ready  in  1  memory accepts/completes the current command this cycle
- overflow  out  1  sticky: a request was dropped because its slot was busy

Behaviour:
- Reset values: all outputs 0; state IDLE; both slots empty; last_grant=CPU.
- Slots:
  - One pending slot per side holding {addr, we, wdata, allow}.
  - req with slot empty: latch at the clock edge; slot is busy from the next cycle.
  - req while slot busy (not completing this cycle): request dropped, overflow<=1. Only reset clears overflow.
  - req in the same cycle that side's done is generated: the slot is freed and the new request is latched (accepted, no overflow).
- States:
  - IDLE: if any slot busy, pick a winner.
    - PPU wins unless last_grant==PPU and the CPU slot is busy; in that case CPU wins.
    - Winner with allow=1: register mem_addr/mem_wdata; mem_rd=!we, mem_wr=we; go to ACCESS(side); last_grant<=side.
    - Winner with allow=0: no memory command; go to DENY(side).
  - ACCESS(side): hold command stable. On the edge where mem_ready=1:
    - mem_rd/mem_wr<=0.
    - For a read: side_rdata<=mem_rdata. For a write: side_rdata is unchanged.
    - side_done<=1; slot freed; go to IDLE.
  - DENY(side): side_done<=1, rdata unchanged, slot freed, go to IDLE. A denied write never reaches memory.
- Latency:
  - With an idle arbiter and mem_ready high in the first command cycle, req in cycle N gives the command visible in N+2 and done in N+3.
  - Each extra cycle of mem_ready low adds one cycle.
  - A denied access gives done in N+3.
- Done behaviour: done pulses are exactly one cycle wide; at most one side is done per cycle.
- mem_ready while no command is asserted: ignored.
- Throughput: one access per 2 cycles minimum (IDLE/ACCESS alternation).
- Reset mid-access: all commands drop in the next cycle, slots clear, and no done is issued.

Test Plan:
- Single CPU read: cpu_req, addr=0x04123, allow=1, mem_ready tied 1, mem_rdata=0x5A -> mem_rd=1 with mem_addr=0x04123 in N+2 only; cpu_done=1 and cpu_rdata=0x5A in N+3.
- Wait states: PPU write, addr=0x201F0, data=0xC3, mem_ready low for 3 command cycles -> mem_wr and mem_wdata=0xC3 held 4 cycles; ppu_done one cycle after the ready cycle; ppu_rdata unchanged.
- Contention: cpu_req and ppu_req in the same cycle, mem_ready=1 -> PPU served first (ppu_done N+3), CPU next (cpu_done N+5); with continuous PPU requests, CPU is still served on every second grant.
- Denied write: cpu_req, we=1, allow=0 -> mem_wr never asserted; cpu_done in N+3; cpu_rdata unchanged.
- Overflow/back-to-back: second cpu_req while the first is pending and mem_ready=0 -> overflow=1 and only one memory command is issued; cpu_req in the cycle of cpu_done -> accepted, overflow unaffected.
- Reset mid-access: assert reset during ACCESS with mem_ready=0 -> mem_rd/mem_wr=0 and both done=0 the next cycle; a fresh request after reset completes normally.
